// File: rtl/md_issue_ctrl_pkg.sv
// Shared MDU op codes, controller states, default latencies and op-class decode.
package md_issue_ctrl_pkg;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int FDIV_LAT_DEF = 3;

    typedef enum logic [3:0] {
        MLU_NONE  = 4'd0,
        MLU_MULT  = 4'd1,
        MLU_MULTU = 4'd2,
        MLU_DIV   = 4'd3,
        MLU_DIVU  = 4'd4,
        MLU_MTHI  = 4'd5,
        MLU_MTLO  = 4'd6,
        MLU_FDIV  = 4'd7,
        MLU_MFHI  = 4'd8,
        MLU_MFLO  = 4'd9
    } mlu_op_e;

    typedef enum logic {
        MDC_IDLE = 1'b0,
        MDC_BUSY = 1'b1
    } mdc_state_e;

    function automatic logic is_long(input logic [3:0] op);
        case (op)
            MLU_MULT, MLU_MULTU, MLU_DIV, MLU_DIVU, MLU_FDIV: is_long = 1'b1;
            default:                                         is_long = 1'b0;
        endcase
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        is_start = is_long(op) || (op == MLU_MTHI) || (op == MLU_MTLO);
    endfunction

    // Codes above mflo are not MDU ops and must never stall D.
    function automatic logic is_md(input logic [3:0] op);
        is_md = (op != MLU_NONE) && (op <= MLU_MFLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_counter.sv
// Shadow latency counter: loads the op latency at issue and counts down to zero.
module md_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] lat_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = lat_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// MDU initiator: issues start/op from E, interlocks D-stage HI/LO users,
// and cross-checks a shadow latency count against the MDU busy line.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int FDIV_LAT = FDIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_mlu_op,
    input  logic [3:0] d_mlu_op,
    input  logic       mlu_busy,
    output logic       start,
    output logic [3:0] mlu_op,
    output logic       stall_md,
    output logic [3:0] pend_op,
    output logic       sync_err
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    logic             start_long;
    logic             d_md;
    logic             busy_cnt;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_sel;

    mdc_state_e       state_q;
    logic [3:0]       pend_q;
    logic             err_q;

    assign start      = e_valid & is_start(e_mlu_op);
    assign start_long = e_valid & is_long(e_mlu_op);
    assign mlu_op     = start ? e_mlu_op : MLU_NONE;
    assign d_md       = is_md(d_mlu_op);
    assign busy_cnt   = ~cnt_zero;

    // The start_long term covers the issue cycle, before MDU busy rises.
    assign stall_md   = d_md & (start_long | busy_cnt | mlu_busy);

    always_comb begin
        lat_sel = '0;
        case (e_mlu_op)
            MLU_MULT, MLU_MULTU: lat_sel = CNT_W'(MULT_LAT);
            MLU_DIV, MLU_DIVU:   lat_sel = CNT_W'(DIV_LAT);
            MLU_FDIV:            lat_sel = CNT_W'(FDIV_LAT);
            default:             lat_sel = '0;
        endcase
    end

    md_lat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (start_long),
        .lat_i  (lat_sel),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDC_IDLE;
            pend_q  <= MLU_NONE;
            err_q   <= 1'b0;
        end else begin
            if ((start_long & busy_cnt) |
                (~start_long & (mlu_busy != busy_cnt))) begin
                err_q <= 1'b1;
            end
            if (start_long) begin
                state_q <= MDC_BUSY;
                pend_q  <= e_mlu_op;
            end else begin
                unique case (state_q)
                    MDC_IDLE: state_q <= MDC_IDLE;
                    MDC_BUSY: begin
                        if (cnt == CNT_W'(1)) begin
                            state_q <= MDC_IDLE;
                            pend_q  <= MLU_NONE;
                        end
                    end
                    default:  state_q <= MDC_IDLE;
                endcase
            end
        end
    end

    assign pend_op  = pend_q;
    assign sync_err = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl with a small pipeline and MDU model.
module tb_md_issue_ctrl;

    logic       clk;
    logic       reset;
    logic       e_valid;
    logic [3:0] e_mlu_op;
    logic [3:0] d_mlu_op;
    logic       mlu_busy;
    logic       start;
    logic [3:0] mlu_op;
    logic       stall_md;
    logic [3:0] pend_op;
    logic       sync_err;

    md_issue_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_mlu_op (e_mlu_op),
        .d_mlu_op (d_mlu_op),
        .mlu_busy (mlu_busy),
        .start    (start),
        .mlu_op   (mlu_op),
        .stall_md (stall_md),
        .pend_op  (pend_op),
        .sync_err (sync_err)
    );

    typedef struct packed {
        logic       st;
        logic [3:0] op;
        logic       stall;
        logic [3:0] pend;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   stream[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   dut_stalls = 0;
    int   cyc = 0;

    // Reference state: remaining busy cycles, op in flight, error flag.
    int   rem = 0;
    int   pend = 0;
    bit   err = 0;
    int   mdu_rem = 0;
    // Pipeline model
    int   d_op = 0;
    int   e_op = 0;
    bit   e_v = 0;
    int   bub_force = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_lat(input int op);
        case (op)
            1, 2:    return 5;
            3, 4:    return 10;
            7:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit tb_start(input int op);
        return (tb_lat(op) > 0) || (op == 5) || (op == 6);
    endfunction

    always @(negedge clk) begin
        exp_t x;
        exp_t a;
        cyc++;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            a.st    = start;
            a.op    = mlu_op;
            a.stall = stall_md;
            a.pend  = pend_op;
            a.err   = sync_err;
            vectors++;
            if (a !== x) begin
                miscompares++;
                $display("FAIL cyc%0d outputs got st=%b op=%0d stall=%b pend=%0d err=%b want st=%b op=%0d stall=%b pend=%0d err=%b",
                         cyc, a.st, a.op, a.stall, a.pend, a.err,
                         x.st, x.op, x.stall, x.pend, x.err);
            end
            if (stall_md === 1'b1) dut_stalls++;
        end
    end

    task automatic step(input bit rst, input bit kill_busy);
        exp_t x;
        int   eo;
        bit   st;
        bit   sl;
        reset    = rst;
        e_valid  = e_v;
        if (e_v) e_mlu_op = 4'(e_op);
        else if (bub_force >= 0) e_mlu_op = 4'(bub_force);
        else e_mlu_op = 4'($urandom_range(0, 15));
        d_mlu_op = 4'(d_op);
        mlu_busy = kill_busy ? 1'b0 : (mdu_rem > 0);
        eo = int'(e_mlu_op);
        st = e_valid && tb_start(eo);
        sl = st && (tb_lat(eo) > 0);
        x.st    = st;
        x.op    = st ? e_mlu_op : 4'd0;
        x.stall = (d_op >= 1 && d_op <= 9) && (sl || rem > 0 || mlu_busy);
        x.pend  = 4'(pend);
        x.err   = err;
        exp_q.push_back(x);
        @(posedge clk);
        if (rst) begin
            rem = 0; pend = 0; err = 0; mdu_rem = 0;
            e_v = 0; d_op = 0;
        end else begin
            if (sl && rem > 0) err = 1;
            if (!sl && (mlu_busy != (rem > 0))) err = 1;
            if (sl) begin
                rem = tb_lat(eo); pend = eo;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) pend = 0;
            end
            if (sl) mdu_rem = tb_lat(eo);
            else if (mdu_rem > 0) mdu_rem--;
            if (x.stall) begin
                e_v = 0;
            end else begin
                e_v  = 1;
                e_op = d_op;
                d_op = (stream.size() > 0) ? stream.pop_front() : 0;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; e_valid = 1'b0; e_mlu_op = '0;
        d_mlu_op = '0; mlu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        run(2);

        // mult with mfhi behind it
        dut_stalls = 0;
        stream.push_back(1); stream.push_back(8);
        run(16);
        chk("mult_stall_len", dut_stalls, 6);

        // div with mflo behind it
        dut_stalls = 0;
        stream.push_back(3); stream.push_back(9);
        run(20);
        chk("div_stall_len", dut_stalls, 11);

        // fdiv then mult back to back
        dut_stalls = 0;
        stream.push_back(7); stream.push_back(1);
        run(16);
        chk("fdiv_mult_hold", dut_stalls, 4);
        chk("fdiv_mult_err", int'(sync_err), 0);

        // mthi then mfhi
        dut_stalls = 0;
        stream.push_back(5); stream.push_back(8);
        run(8);
        chk("mthi_no_stall", dut_stalls, 0);
        chk("mthi_pend", int'(pend_op), 0);

        // reset in the middle of a div
        stream.push_back(3); stream.push_back(9);
        run(4);
        chk("div_pend_mid", int'(pend_op), 3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("div_reset_pend", int'(pend_op), 0);
        run(4);

        // MDU busy dropped mid-mult
        stream.push_back(2);
        run(4);
        step(1'b0, 1'b1);
        run(12);
        chk("sync_err_sticky", int'(sync_err), 1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("sync_err_reset", int'(sync_err), 0);

        // bubbles carrying a mult code
        bub_force = 1;
        run(6);
        bub_force = -1;

        for (int i = 0; i < 600; i++) begin
            if (stream.size() == 0) begin
                if ($urandom_range(0, 1) == 0) stream.push_back(0);
                else stream.push_back(int'($urandom_range(1, 11)));
            end
            step(($urandom_range(0, 99) == 0), 1'b0);
        end
        run(3);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
